// File: rtl/cbus_responder.sv
// cbus_pkg: request/response types shared by cbus masters and responders.
//
// cbus_responder: word-addressed memory (2^MEM_LOG2 x 32-bit) serving cbus bursts.
//   clk    in   clock, all state updates on the rising edge
//   resetn in   synchronous active-low reset (memory contents are preserved)
//   creq   in   burst request: valid, is_write, size, addr, strobe, data, len
//   cresp  out  burst response: ready, last, data
// A request is accepted in IDLE, waits LATENCY cycles, then serves len+1 beats
// that wrap inside a (len+1)-word aligned window around the start address.

package cbus_pkg;

    // Burst length codes: beat count is len + 1.
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_LOG2 = 10,
    parameter int unsigned LATENCY  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int unsigned Depth = 1 << MEM_LOG2;
    localparam int unsigned IdxW  = MEM_LOG2;
    localparam logic [3:0]  LatW  = 4'(LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBeat
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   base_q, base_d;
    logic [3:0]        len_q, len_d;
    logic              wr_q, wr_d;
    logic [3:0]        i_q, i_d;
    logic [3:0]        w_q, w_d;

    logic [31:0]       mem [Depth];

    logic [IdxW-1:0]   len_ext;
    logic [IdxW-1:0]   i_ext;
    logic [IdxW-1:0]   beat_idx;
    logic              beat_fire;
    logic              mem_we;

    // Size is informational only and the low/high address bits alias away.
    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:MEM_LOG2+2]};

    // Wrap within the len+1 aligned window: upper bits fixed from the base,
    // lower bits count up from the base offset and roll over.
    assign len_ext  = IdxW'(len_q);
    assign i_ext    = IdxW'(i_q);
    assign beat_idx = (base_q & ~len_ext) | ((base_q + i_ext) & len_ext);

    // A beat completes only in BEAT with valid held; reset suppresses it so no
    // write lands on the reset edge.
    assign beat_fire = (state_q == StBeat) && creq.valid && resetn;
    assign mem_we    = beat_fire && wr_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        wr_d    = wr_q;
        i_d     = i_q;
        w_d     = w_q;

        unique case (state_q)
            StIdle: begin
                if (creq.valid) begin
                    base_d  = creq.addr[MEM_LOG2+1:2];
                    len_d   = creq.len;
                    wr_d    = creq.is_write;
                    i_d     = 4'd0;
                    w_d     = LatW;
                    state_d = (LATENCY == 0) ? StBeat : StWait;
                end
            end
            StWait: begin
                w_d = w_q - 4'd1;
                if (!creq.valid) begin
                    // Master abandoned the burst.
                    state_d = StIdle;
                end else if (w_q == 4'd1) begin
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (!creq.valid) begin
                    state_d = StIdle;
                end else begin
                    i_d = i_q + 4'd1;
                    if (i_q == len_q) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cresp.ready = beat_fire;
        cresp.last  = beat_fire && (i_q == len_q);
        cresp.data  = (beat_fire && !wr_q) ? mem[beat_idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= 4'd0;
            wr_q    <= 1'b0;
            i_q     <= 4'd0;
            w_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            i_q     <= i_d;
            w_q     <= w_d;
        end
    end

    // Memory has no reset; byte lanes are selected purely by strobe.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (creq.strobe[k]) begin
                    mem[beat_idx][8*k +: 8] <= creq.data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_responder.sv
// Bench for cbus_responder: two instances (LATENCY=2 and LATENCY=0) on one
// clock/reset; a selector routes the shared request to one of them. Expected
// beats are queued when a burst is issued and popped as ready beats appear.
module tb_cbus_responder;
    import cbus_pkg::*;

    localparam int unsigned MemLog2 = 10;
    localparam int unsigned Words   = 1 << MemLog2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sel;
    cbus_req_t  req;
    cbus_req_t  creq2, creq0;
    cbus_resp_t cresp2, cresp0, resp_m;

    assign creq2  = sel ? '0 : req;
    assign creq0  = sel ? req : '0;
    assign resp_m = sel ? cresp0 : cresp2;

    cbus_responder #(
        .MEM_LOG2(MemLog2),
        .LATENCY (2)
    ) u_dut_lat2 (
        .clk   (clk),
        .resetn(resetn),
        .creq  (creq2),
        .cresp (cresp2)
    );

    cbus_responder #(
        .MEM_LOG2(MemLog2),
        .LATENCY (0)
    ) u_dut_lat0 (
        .clk   (clk),
        .resetn(resetn),
        .creq  (creq0),
        .cresp (cresp0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model2 [Words];
    logic [31:0] model0 [Words];
    logic [31:0] wdat [16];
    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input int unsigned idx);
        return sel ? model0[idx] : model2[idx];
    endfunction

    task automatic model_wr(input int unsigned idx, input logic [31:0] val);
        if (sel) model0[idx] = val;
        else     model2[idx] = val;
    endtask

    // Word index of beat i: aligned window of len+1 words containing the base.
    function automatic int unsigned model_idx(input logic [31:0] addr, input logic [3:0] len,
                                              input int unsigned i);
        int unsigned base, n, start;
        base  = (addr >> 2) % Words;
        n     = int'(len) + 1;
        start = base - (base % n);
        return start + ((base - start + i) % n);
    endfunction

    // Starts and ends #1 after a rising edge. stop_at >= 0 aborts after that
    // many beats, either by reset or by dropping valid. chain keeps valid high
    // so the caller can issue the next burst back-to-back.
    task automatic burst(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input int exp_lat, input int stop_at,
                         input logic by_reset, input logic chain);
        int          nbeats, beat, cyc;
        int unsigned idx;
        logic [31:0] cur, nxt;
        nbeats = (stop_at >= 0 && stop_at <= int'(len)) ? stop_at : int'(len) + 1;
        for (int b = 0; b < nbeats; b++) begin
            idx = model_idx(addr, len, b);
            cur = model_rd(idx);
            if (wr) begin
                nxt = cur;
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) nxt[8*k +: 8] = wdat[b][8*k +: 8];
                end
                model_wr(idx, nxt);
                exp_data_q.push_back(32'd0);
            end else begin
                exp_data_q.push_back(cur);
            end
            exp_last_q.push_back(b == int'(len));
        end

        req.valid    = 1'b1;
        req.is_write = wr;
        req.addr     = addr;
        req.len      = len;
        req.strobe   = strb;
        req.data     = wdat[0];
        req.size     = 3'($urandom);
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 64) begin
            @(negedge clk);
            if (cyc == 0) check_eq("accept_no_ready", resp_m.ready, 1'b0);
            if (beat > 0) check_eq("ready_held", resp_m.ready, 1'b1);
            if (resp_m.ready) begin
                if (beat == 0) check_eq("first_ready_cycle", cyc, exp_lat);
                check_eq("beat_data", resp_m.data, exp_data_q.pop_front());
                check_eq("beat_last", resp_m.last, exp_last_q.pop_front());
                beat++;
            end else begin
                check_eq("idle_last", resp_m.last, 1'b0);
                check_eq("idle_data", resp_m.data, 32'd0);
            end
            @(posedge clk);
            #1;
            cyc++;
            // Mid-burst changes to addr/len must not affect the burst.
            req.addr = addr ^ 32'h0000_0FF0;
            req.len  = ~len;
            req.data = wdat[beat % 16];
            if (stop_at >= 0 && beat == stop_at) begin
                if (by_reset) resetn = 1'b0;
                else          req.valid = 1'b0;
                @(negedge clk);
                check_eq("abort_ready", resp_m.ready, 1'b0);
                check_eq("abort_last", resp_m.last, 1'b0);
                check_eq("abort_data", resp_m.data, 32'd0);
                @(posedge clk);
                #1;
                resetn    = 1'b1;
                req.valid = 1'b0;
            end
        end
        check_eq("beats_seen", beat, nbeats);
        check_eq("sb_empty", exp_data_q.size(), 0);
        exp_data_q.delete();
        exp_last_q.delete();
        if (!chain) req.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req.valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int j = 0; j < int'(Words); j++) begin
            model2[j] = 32'd0;
            model0[j] = 32'd0;
        end
        resetn = 1'b0;
        sel    = 1'b0;
        req    = '0;
        req.valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready2", cresp2.ready, 1'b0);
        check_eq("rst_last2", cresp2.last, 1'b0);
        check_eq("rst_data2", cresp2.data, 32'd0);
        check_eq("rst_ready0", cresp0.ready, 1'b0);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        resetn    = 1'b1;

        // 16-beat write at 0x100, data 0..15, first ready 3 cycles after valid.
        for (int j = 0; j < 16; j++) wdat[j] = j;
        burst(1'b1, 32'h100, MLEN16, 4'hF, 3, -1, 1'b0, 1'b0);
        idle(1);
        // Wrapping read from 0x108: 2..15,0,1.
        burst(1'b0, 32'h108, MLEN16, 4'h0, 3, -1, 1'b0, 1'b0);
        idle(1);
        // Byte-strobed merge into word 0x41 (holds 1) -> 0x00BB00DD.
        wdat[0] = 32'hAABB_CCDD;
        burst(1'b1, 32'h104, MLEN1, 4'b0101, 3, -1, 1'b0, 1'b0);
        burst(1'b0, 32'h104, MLEN1, 4'h0, 3, -1, 1'b0, 1'b0);
        // Upper and lower address bits alias away.
        burst(1'b0, 32'hFFFF_F10B, MLEN4, 4'h0, 3, -1, 1'b0, 1'b0);

        // Valid dropped during WAIT: no beat, no write.
        wdat[0]      = 32'hDEAD_BEEF;
        req.valid    = 1'b1;
        req.is_write = 1'b1;
        req.addr     = 32'h104;
        req.len      = MLEN1;
        req.strobe   = 4'hF;
        req.data     = wdat[0];
        @(negedge clk);
        check_eq("wait_drop_accept", resp_m.ready, 1'b0);
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("wait_drop_ready", resp_m.ready, 1'b0);
            @(posedge clk);
            #1;
        end
        burst(1'b0, 32'h104, MLEN1, 4'h0, 3, -1, 1'b0, 1'b0);

        // Reset after beat 5 of a 16-beat write; readback shows only 5 updated.
        for (int j = 0; j < 16; j++) wdat[j] = 32'h5500 + j;
        burst(1'b1, 32'h200, MLEN16, 4'hF, 3, -1, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) wdat[j] = 32'hA0 + j;
        burst(1'b1, 32'h200, MLEN16, 4'hF, 3, 5, 1'b1, 1'b0);
        burst(1'b0, 32'h200, MLEN16, 4'h0, 3, -1, 1'b0, 1'b0);

        // LATENCY=0 instance: back-to-back bursts need one idle cycle between.
        idle(1);
        sel = 1'b1;
        for (int j = 0; j < 16; j++) wdat[j] = 32'h10 + j;
        burst(1'b1, 32'h00, MLEN4, 4'hF, 1, -1, 1'b0, 1'b1);
        burst(1'b0, 32'h0C, MLEN4, 4'h0, 1, -1, 1'b0, 1'b1);
        burst(1'b0, 32'h04, MLEN2, 4'h0, 1, -1, 1'b0, 1'b0);
        idle(1);
        // Valid dropped in BEAT after 2 beats: remaining words untouched.
        for (int j = 0; j < 16; j++) wdat[j] = 32'h70 + j;
        burst(1'b1, 32'h00, MLEN4, 4'hF, 1, 2, 1'b0, 1'b0);
        burst(1'b0, 32'h00, MLEN4, 4'h0, 1, -1, 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_responder.md
CBUS_RESPONDER -- requirements
Module: cbus_responder

Interface
REQ-001 Parameter MEM_LOG2, default 10, meaning log2 of the number of 32-bit words in the internal memory.
REQ-002 Parameter LATENCY, default 2, meaning idle cycles between request acceptance and the first data beat; legal range 0..15.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port resetn  input  1  reset, synchronous, active-low.
REQ-005 Port creq  input  cbus_req_t  burst request: valid, is_write, size, addr, strobe, data, len.
REQ-006 Port cresp  output  cbus_resp_t  burst response: ready, last, data.

Function
REQ-007 The block SHALL be the cbus responder side: a word-addressed memory of 2^MEM_LOG2 words that serves cbus bursts.
REQ-008 The FSM SHALL have three states: IDLE, WAIT, BEAT.
REQ-009 IDLE with creq.valid=1: the block SHALL latch addr, len and is_write, clear beat counter i, and load wait counter w=LATENCY.
REQ-010 From that IDLE cycle the FSM SHALL go to BEAT if LATENCY=0, otherwise to WAIT.
REQ-011 WAIT: w SHALL decrement each cycle, and the FSM SHALL enter BEAT on the cycle after w reaches 1; ready=0 throughout WAIT.
REQ-012 Beat count SHALL be len+1: MLEN1=0, MLEN2=1, MLEN4=3, MLEN8=7, MLEN16=15; i and len are 4 bits.
REQ-013 Beat word index SHALL be computed as: base=latched addr[MEM_LOG2+1:2]; index = (base & ~len) | ((base + i) & len), i.e. wrap within a len+1-aligned window.
REQ-014 Address bits above MEM_LOG2+1 SHALL be ignored (aliasing); addr[1:0] SHALL be ignored.
REQ-015 BEAT: cresp.ready SHALL equal creq.valid; one beat completes on each cycle with ready=1.
REQ-016 cresp.last SHALL equal ready AND (i==len).
REQ-017 Read beat: cresp.data SHALL equal mem[index] combinationally in the same cycle as ready.
REQ-018 Write beat: byte k of mem[index] SHALL take creq.data byte k at the clock edge iff creq.strobe[k]=1; cresp.data SHALL be 0.
REQ-019 creq.size SHALL NOT affect behaviour; strobe alone selects written bytes.
REQ-020 On each completed beat, i SHALL increment; on the last beat the FSM SHALL return to IDLE.
REQ-021 Back-to-back bursts: a new request SHALL NOT be accepted in the cycle of the last beat; acceptance is earliest on the following cycle.
REQ-022 creq.valid deasserted in WAIT or BEAT is a protocol violation: the FSM SHALL return to IDLE, no write SHALL occur in that cycle, and ready/last SHALL stay 0.
REQ-023 In IDLE and WAIT, cresp.ready, cresp.last and cresp.data SHALL all be 0.
REQ-024 Latched fields SHALL be used for addressing; changes to creq.addr or creq.len mid-burst SHALL be ignored.

Reset
REQ-025 resetn=0 at a clock edge SHALL force state=IDLE, i=0, w=0 and clear the latched request fields.
REQ-026 During and after reset, cresp.ready=0, cresp.last=0 and cresp.data=0 until a new burst reaches BEAT.
REQ-027 Memory contents SHALL NOT be cleared by reset; a burst interrupted by reset leaves already-written beats in place.
REQ-028 Reset asserted mid-burst SHALL abort it with no further writes from the reset edge onward.

Verification
REQ-029 LATENCY=2, write MLEN16 at addr 0x100, strobe 1111, data 0..15 -> first ready exactly 3 cycles after valid; 16 consecutive ready cycles; last on beat 16 only.
REQ-030 Read MLEN16 at addr 0x108, after the write above -> data sequence 2,3,...,15,0,1 (wrap at word 15->0); last on the 16th beat.
REQ-031 Write MLEN1 at 0x104, strobe 0101, data 0xAABBCCDD to a word holding 0x00000001 -> subsequent read returns 0x00BB00DD.
REQ-032 LATENCY=0, read MLEN4 at 0x0C -> ready in the cycle after acceptance; indices 3,0,1,2; idle gap of at least one cycle before the next burst's first ready.
REQ-033 resetn=0 after beat 5 of a 16-beat write -> ready=0 from the next cycle; words 0-4 updated, words 5-15 unchanged; FSM in IDLE.
REQ-034 Drop creq.valid during WAIT -> FSM back to IDLE, no ready pulse, memory unchanged.
